// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN for single-cycle combinational multiplies.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] Rs1_data,
    input  logic [XLEN-1:0] Rs2_data,
    input  logic [4:0]      Rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      Rd_out,
    output logic            W_en
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_op;
    logic [4:0]        r_rd;
    logic              r_neg_p;
    logic              r_neg_r;
    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_div;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rd_out;

    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_ma;
    logic [XLEN-1:0]   w_mb;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_fast_mul;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_res;

    logic [2*XLEN-1:0] w_acc_n;
    logic [XLEN:0]     w_sh;
    logic [XLEN:0]     w_sub;
    logic [XLEN-1:0]   w_rem_n;
    logic [XLEN-1:0]   w_quo_n;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_calc_res;

    assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                        (funct3 == 3'b110);
    assign w_sa = w_a_signed & Rs1_data[XLEN-1];
    assign w_sb = w_b_signed & Rs2_data[XLEN-1];
    assign w_ma = w_sa ? -Rs1_data : Rs1_data;
    assign w_mb = w_sb ? -Rs2_data : Rs2_data;

    assign w_div_zero = funct3[2] & (Rs2_data == '0);
    assign w_div_ovf  = funct3[2] & ~funct3[0] &
                        (Rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &
                        (&Rs2_data);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_mprod;
    logic [2*XLEN-1:0] w_fprod;

    assign w_mprod    = {{XLEN{1'b0}}, w_ma} * {{XLEN{1'b0}}, w_mb};
    assign w_fprod    = (w_sa ^ w_sb) ? -w_mprod : w_mprod;
    assign w_fast_mul = ~funct3[2];
`else
    assign w_fast_mul = 1'b0;
`endif

    assign w_fast = w_div_zero | w_div_ovf | w_fast_mul;

    always_comb begin
        w_fast_res = '0;
        if (w_div_zero) begin
            w_fast_res = funct3[1] ? Rs1_data : '1;
        end else if (w_div_ovf) begin
            w_fast_res = funct3[1] ? '0 : Rs1_data;
        end
`ifdef MULDIV_FAST_MUL_EN
        if (w_fast_mul) begin
            w_fast_res = (funct3[1:0] == 2'b00) ? w_fprod[XLEN-1:0]
                                                : w_fprod[2*XLEN-1:XLEN];
        end
`endif
    end

    // One iteration of both datapaths; the latched op picks which result matters.
    assign w_acc_n = r_mplier[0] ? r_acc + r_mcand : r_acc;
    assign w_sh    = {r_rem, r_quo[XLEN-1]};
    assign w_sub   = w_sh - {1'b0, r_div};
    assign w_rem_n = w_sub[XLEN] ? w_sh[XLEN-1:0] : w_sub[XLEN-1:0];
    assign w_quo_n = {r_quo[XLEN-2:0], ~w_sub[XLEN]};
    assign w_prod  = r_neg_p ? -w_acc_n : w_acc_n;

    always_comb begin
        w_calc_res = '0;
        if (!r_op[2]) begin
            w_calc_res = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0]
                                              : w_prod[2*XLEN-1:XLEN];
        end else if (r_op[1]) begin
            w_calc_res = r_neg_r ? -w_rem_n : w_rem_n;
        end else begin
            w_calc_res = r_neg_p ? -w_quo_n : w_quo_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = w_fast ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_rd     <= '0;
            r_neg_p  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_result <= '0;
            r_rd_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op     <= funct3;
                        r_rd     <= Rd_in;
                        r_neg_p  <= w_sa ^ w_sb;
                        r_neg_r  <= w_sa;
                        r_acc    <= '0;
                        r_mcand  <= {{XLEN{1'b0}}, w_ma};
                        r_mplier <= w_mb;
                        r_rem    <= '0;
                        r_quo    <= w_ma;
                        r_div    <= w_mb;
                        r_cnt    <= CW'(XLEN - 1);
                        if (w_fast) begin
                            r_result <= w_fast_res;
                            r_rd_out <= Rd_in;
                        end
                    end
                end
                S_CALC: begin
                    r_acc    <= w_acc_n;
                    r_mcand  <= {r_mcand[2*XLEN-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
                    r_rem    <= w_rem_n;
                    r_quo    <= w_quo_n;
                    if (r_cnt == '0) begin
                        r_result <= w_calc_res;
                        r_rd_out <= r_rd;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign Rd_out = r_rd_out;
    assign W_en   = done & (r_rd_out != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes model results, monitor pops on done.
// Honours MULDIV_FAST_MUL_EN for expected multiply latency.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] Rs1_data;
    logic [31:0] Rs2_data;
    logic [4:0]  Rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  Rd_out;
    logic        W_en;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .Rs1_data(Rs1_data), .Rs2_data(Rs2_data), .Rd_in(Rd_in),
        .busy(busy), .done(done), .result(result), .Rd_out(Rd_out),
        .W_en(W_en)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] pa, pb, p;
        int sa, sb;
        if (!f[2]) begin
            pa = (f == 3'b001 || f == 3'b010) ? {{32{a[31]}}, a} : {32'd0, a};
            pb = (f == 3'b001) ? {{32{b[31]}}, b} : {32'd0, b};
            p  = pa * pb;
            return (f == 3'b000) ? p[31:0] : p[63:32];
        end
        if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return f[1] ? 32'd0 : 32'h8000_0000;
        sa = a;
        sb = b;
        case (f)
            3'b100:  return $unsigned(sa / sb);
            3'b110:  return $unsigned(sa % sb);
            3'b101:  return a / b;
            default: return a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        bit fast;
        fast = f[2] && (b == 0 ||
               (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) fast = 1;
`endif
        return fast ? 1 : 33;
    endfunction

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!done) begin
                chk("wen_idle", {31'd0, W_en}, 32'd0);
            end else if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: result=%h rd=%0d", result, Rd_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", result, e.res);
                chk("rd_out", {27'd0, Rd_out}, {27'd0, e.rd});
                chk("w_en", {31'd0, W_en}, {31'd0, (e.rd != 0)});
            end
        end
    end

    task automatic wait_idle();
        int cyc = 0;
        while (busy && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input bit poke);
        int  cyc;
        bit  busy_ok;
        exp_t e;
        wait_idle();
        start = 1; funct3 = f; Rs1_data = a; Rs2_data = b; Rd_in = rd;
        e.res = model(f, a, b);
        e.rd  = rd;
        q.push_back(e);
        @(posedge clk); #1;
        start = 0;
        cyc = 1;
        busy_ok = 1;
        while (!done && cyc < 100) begin
            if (!busy) busy_ok = 0;
            if (poke && cyc == 5) begin
                start = 1; funct3 = 3'b101;
                Rs1_data = $urandom; Rs2_data = 32'd3; Rd_in = 5'd9;
            end else begin
                start = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, exp_lat(f, a, b));
        chk("busy_held", {31'd0, busy_ok}, 32'd1);
        if (poke) begin
            start = 1; funct3 = 3'b000; Rd_in = 5'd7;
            @(posedge clk); #1;
            start = 0;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return $urandom_range(0, 300);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc;
        rst_n = 0; start = 0; funct3 = 0;
        Rs1_data = 0; Rs2_data = 0; Rd_in = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd", {27'd0, Rd_out}, 32'd0);
        chk("rst_wen", {31'd0, W_en}, 32'd0);
        rst_n = 1;
        mon_en = 1;

        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0);
        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
        do_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd3, 0);
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
        do_op(3'b101, 32'd100, 32'd7, 5'd8, 0);
        do_op(3'b111, 32'd100, 32'd7, 5'd10, 0);
        do_op(3'b101, 32'd5, 32'd0, 5'd11, 0);
        do_op(3'b110, 32'd5, 32'd0, 5'd12, 0);
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0);
        do_op(3'b000, 32'd3, 32'd5, 5'd0, 0);
        do_op(3'b100, 32'd1000, 32'hFFFF_FFF3, 5'd15, 1);
        do_op(3'b001, 32'h1234_5678, 32'h8765_4321, 5'd16, 1);

        // Abort mid-CALC with a one-edge reset.
        wait_idle();
        start = 1; funct3 = 3'b111; Rs1_data = 32'd999; Rs2_data = 32'd10;
        Rd_in = 5'd3;
        @(posedge clk); #1;
        start = 0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_wen", {31'd0, W_en}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        do_op(3'b101, 32'd77, 32'd7, 5'd20, 0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] f;
            logic [31:0] a, b;
            logic [4:0] rd;
            f  = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            rd = 5'($urandom_range(0, 31));
            do_op(f, a, b, rd, ($urandom_range(0, 7) == 0));
        end

        cyc = 0;
        while (q.size() != 0 && cyc < 50) begin
            @(posedge clk);
            cyc++;
        end
        repeat (3) @(posedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
